// File: rtl/mod_2011_digit_reducer.sv
// rtl/mod_2011_digit_reducer.sv - streaming MSD-first digit reducer, operand mod M
module mod_2011_digit_reducer #(
    parameter int M  = 2011,
    parameter int MW = 11,
    parameter int DW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_digit,
    input  logic          in_first,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [MW-1:0] out_res
);

    // Working value holds one shifted residue plus a digit; compares get one extra bit
    localparam int TW = MW + DW;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_REDUCE,
        ST_OUTPUT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [MW-1:0]   r_acc;
    logic [TW-1:0]   r_t;
    logic [CW-1:0]   r_cnt;
    logic            r_lst;

    logic            w_accept;
    logic            w_last_stage;
    logic [TW-1:0]   w_t_in;
    logic [TW:0]     w_m_shift;
    logic            w_ge;
    logic [TW-1:0]   w_t_red;

    assign w_accept     = (r_state == ST_ACCEPT) && in_valid;
    assign w_last_stage = (r_state == ST_REDUCE) && (r_cnt == '0);

    // Horner step: shifting the residue left by DW leaves the low bits free for the digit
    assign w_t_in = {(in_first ? {MW{1'b0}} : r_acc), in_digit};

    // One conditional-subtract stage of M scaled by 2^cnt
    assign w_m_shift = (TW + 1)'(M) << r_cnt;
    assign w_ge      = {1'b0, r_t} >= w_m_shift;
    assign w_t_red   = w_ge ? (r_t - w_m_shift[TW-1:0]) : r_t;

    assign in_ready  = (r_state == ST_ACCEPT);
    assign out_valid = (r_state == ST_OUTPUT);
    assign out_res   = r_acc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode: accept a digit, reduce DW stages, optionally present result
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ACCEPT: begin
                if (in_valid) begin
                    w_next = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (r_cnt == '0) begin
                    w_next = r_lst ? ST_OUTPUT : ST_ACCEPT;
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    w_next = ST_ACCEPT;
                end
            end
            default: w_next = ST_ACCEPT;
        endcase
    end

    // Datapath: load working value on accept, subtract one stage per REDUCE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_t   <= '0;
            r_cnt <= '0;
            r_lst <= 1'b0;
        end else if (w_accept) begin
            r_t   <= w_t_in;
            r_lst <= in_last;
            r_cnt <= CW'(DW - 1);
        end else if (r_state == ST_REDUCE) begin
            r_t   <= w_t_red;
            r_cnt <= r_cnt - CW'(1);
            if (w_last_stage) begin
                r_acc <= w_t_red[MW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mod_2011_digit_reducer.sv
// tb/tb_mod_2011_digit_reducer.sv - randomized self-checking bench for mod_2011_digit_reducer
module tb_mod_2011_digit_reducer;

    localparam int M  = 2011;
    localparam int MW = 11;
    localparam int DW = 3;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_first  = 1'b0;
    logic          in_last   = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] in_digit  = '0;
    logic          in_ready;
    logic          out_valid;
    logic [MW-1:0] out_res;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int     ops[$];
    longint m_acc = 0;

    mod_2011_digit_reducer #(.M(M), .MW(MW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digit  (in_digit),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full integer value of the operand (optionally prefixed by the previous residue), then mod M
    function automatic longint model(input longint prev, input bit first);
        longint v;
        v = first ? 0 : prev;
        foreach (ops[i]) v = v * (64'd1 << DW) + ops[i];
        return v % M;
    endfunction

    task automatic push(input int d, input bit f, input bit l, output int hs);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_digit = DW'(d);
        in_first = f;
        in_last  = l;
        hs = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_op(input bit first, output int hs0);
        int hs;
        hs0 = 0;
        for (int i = 0; i < ops.size(); i++) begin
            push(ops[i], first && (i == 0), i == ops.size() - 1, hs);
            if (i == 0) hs0 = hs;
        end
    endtask

    task automatic get_res(input string tag, input longint exp, input int hold, output int oc);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq({tag, "_timeout"}, 0, 1);
        oc = cyc;
        out_ready = 1'b0;
        check_eq(tag, out_res, exp);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, out_valid, 1);
            check_eq({tag, "_hold_res"}, out_res, exp);
            check_eq({tag, "_hold_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_eq({tag, "_ready_after"}, in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, oc, nd, k;
        bit fst;
        longint exp;

        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_res", out_res, 0);
        rst_n = 1'b1;
        @(negedge clk);

        ops = '{5};
        exp = model(m_acc, 1);
        send_op(1, hs);
        get_res("single5", exp, 0, oc);
        check_eq("single5_latency", oc - hs, DW + 1);
        m_acc = exp;

        ops = '{3, 7, 3, 3};
        exp = model(m_acc, 1);
        send_op(1, hs);
        get_res("op2011", exp, 0, oc);
        check_eq("op2011_latency", oc - hs, 4 * (DW + 1));
        m_acc = exp;

        ops = '{3, 7, 3, 2};
        exp = model(m_acc, 1);
        send_op(1, hs);
        get_res("op2010", exp, 0, oc);
        m_acc = exp;

        ops = '{7, 7, 7, 7};
        exp = model(m_acc, 1);
        send_op(1, hs);
        get_res("op4095_bp", exp, 10, oc);
        m_acc = exp;

        ops = '{1, 0};
        exp = model(m_acc, 1);
        send_op(1, hs);
        get_res("acc_first", exp, 0, oc);
        m_acc = exp;

        ops = '{7, 7, 7, 7};
        exp = model(m_acc, 1);
        send_op(1, hs);
        get_res("op4095_again", exp, 0, oc);
        m_acc = exp;

        ops = '{1, 0};
        exp = model(m_acc, 0);
        send_op(0, hs);
        get_res("acc_continue", exp, 0, oc);
        m_acc = exp;

        push(7, 1, 0, hs);
        push(7, 0, 0, hs);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_out_res", out_res, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0;
        @(negedge clk);

        ops = '{6};
        exp = model(m_acc, 1);
        send_op(1, hs);
        get_res("after_rst6", exp, 0, oc);
        m_acc = exp;

        for (int it = 0; it < 40; it++) begin
            nd = $urandom_range(1, 6);
            ops.delete();
            for (int j = 0; j < nd; j++) ops.push_back(int'($urandom_range(0, (1 << DW) - 1)));
            fst = ($urandom_range(0, 4) != 0);
            k = $urandom_range(0, 3);
            repeat (k) @(negedge clk);
            exp = model(m_acc, fst);
            send_op(fst, hs);
            get_res($sformatf("rand%0d", it), exp, $urandom_range(0, 3), oc);
            m_acc = exp;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
